gmem_burst_splitter: RTL and testbench
======================================

// Module: gmem_burst_splitter
// PURPOSE
//  Splits a kernel read request (beat-aligned start address + beat count) into
//  AXI-legal AR bursts for global memory. Sits directly downstream of
//  addr_slicer: consumes its o_gmem_raddr as i_req_addr and feeds the AXI AR channel.
//  Sub-bursts never exceed MAX_BURST_BEATS and never cross a BOUNDARY_BYTES line.
// PARAMETERS
//  FULL_ADDR_WIDTH  64    byte-address width of request and AR address
//  DATA_WIDTH       512   AXI data width in bits; BEAT_BYTES = DATA_WIDTH/8
//  LEN_WIDTH        32    width of request beat count
//  MAX_BURST_BEATS  64    max beats per AR burst (1..256, power of 2)
//  BOUNDARY_BYTES   4096  no-cross boundary (power of 2, >= BEAT_BYTES*MAX_BURST_BEATS not required)
// PORTS
//  i_clk         in   1                clock
//  i_rst_n       in   1                asynchronous active-low reset
//  i_req_valid   in   1                request valid
//  o_req_ready   out  1                request accepted when valid&ready
//  i_req_addr    in   FULL_ADDR_WIDTH  start byte address (from addr_slicer)
//  i_req_beats   in   LEN_WIDTH        total beats requested (0 allowed)
//  o_ar_valid    out  1                AR burst valid
//  i_ar_ready    in   1                AR burst accepted when valid&ready
//  o_ar_addr     out  FULL_ADDR_WIDTH  burst start byte address
//  o_ar_len      out  8                AXI ARLEN (beats-1)
//  o_busy        out  1                request in progress
//  o_done        out  1                1-cycle pulse: all bursts of request issued
// BEHAVIOUR
//  - Reset (i_rst_n low, async): state IDLE; o_ar_valid=0, o_ar_addr=0, o_ar_len=0,
//    o_busy=0, o_done=0, o_req_ready=0 while in reset, 1 after release in IDLE.
//  - Reset mid-request: in-flight request and pending AR discarded, no o_done.
//  - States: IDLE, ISSUE, DONE.
//  - IDLE: o_req_ready=1. On handshake latch addr with low log2(BEAT_BYTES) bits
//    forced to 0, remaining=i_req_beats. beats>0 -> ISSUE; beats==0 -> DONE.
//  - ISSUE entry/after each AR handshake, compute next chunk from registers:
//    to_bnd = (BOUNDARY_BYTES - addr mod BOUNDARY_BYTES)/BEAT_BYTES;
//    chunk = min(remaining, MAX_BURST_BEATS, to_bnd) (>=1).
//    o_ar_valid=1, o_ar_addr=addr, o_ar_len=chunk-1, all registered.
//  - First AR valid one cycle after request handshake.
//  - o_ar_addr/o_ar_len stable while o_ar_valid & !i_ar_ready.
//  - On AR handshake: addr += chunk*BEAT_BYTES (mod 2^FULL_ADDR_WIDTH),
//    remaining -= chunk. remaining>0 -> next burst valid next cycle (one AR
//    per two cycles max is not allowed: next burst valid the cycle after,
//    o_ar_valid may stay high continuously, i.e. back-to-back). remaining==0 -> DONE.
//  - DONE: o_done=1 for exactly one cycle, o_ar_valid=0, then IDLE.
//  - o_busy=1 in ISSUE and DONE; o_req_ready=0 outside IDLE.
//  - Address wrap at 2^FULL_ADDR_WIDTH wraps silently; boundary rule still applies.
//  - Request handshake and AR handshake never coincide (ready only in IDLE).
// TESTING
//  1 DATA_WIDTH=512: addr 0x0F80, beats 8 -> AR (0x0F80,len 1) then (0x1000,len 5);
//    o_done one cycle after second handshake.
//  2 addr 0x0, beats 200, MAX 64 -> lens 63,63,63,7 at 0x0,0x1000,0x2000,0x3000.
//  3 i_ar_ready low 5 cycles on first burst -> o_ar_addr/o_ar_len unchanged,
//    o_ar_valid held high; no extra bursts.
//  4 beats 0 at any addr -> no o_ar_valid; o_done pulse 1 cycle after accept.
//  5 addr 0x1234 (misaligned) beats 1 -> AR (0x1200,len 0).
//  6 assert i_rst_n low during 2nd of 4 bursts -> outputs reset immediately,
//    no o_done; new request after release processed normally.

Source files
------------

// File: rtl/gmem_burst_splitter.sv
// Splits a beat-aligned global-memory read request into AXI AR bursts that
// never exceed MAX_BURST_BEATS and never cross a BOUNDARY_BYTES line.
module gmem_burst_splitter #(
    parameter int FULL_ADDR_WIDTH = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int LEN_WIDTH       = 32,
    parameter int MAX_BURST_BEATS = 64,
    parameter int BOUNDARY_BYTES  = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [FULL_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [LEN_WIDTH-1:0]       i_req_beats,
    output logic                       o_ar_valid,
    input  logic                       i_ar_ready,
    output logic [FULL_ADDR_WIDTH-1:0] o_ar_addr,
    output logic [7:0]                 o_ar_len,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int AW         = FULL_ADDR_WIDTH;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_LOG2  = $clog2(BEAT_BYTES);
    localparam int BND_LOG2   = $clog2(BOUNDARY_BYTES);
    localparam int OFF_W      = BND_LOG2 - BEAT_LOG2;
    localparam int BND_BEATS  = 1 << OFF_W;
    localparam logic [AW-1:0] LOW_MASK = AW'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t               state;
    logic [AW-1:0]        addr;
    logic [LEN_WIDTH-1:0] rem;
    logic [8:0]           chunk;

    logic [AW-1:0]        aligned;
    logic [AW-1:0]        next_addr;
    logic [LEN_WIDTH-1:0] next_rem;
    logic [8:0]           req_chunk;
    logic [8:0]           next_chunk;

    // off = beat index of the address inside its boundary line
    function automatic logic [8:0] chunk_of(input logic [OFF_W-1:0] off,
                                            input logic [LEN_WIDTH-1:0] beats);
        logic [OFF_W:0] to_bnd;
        logic [8:0]     c;
        to_bnd = (OFF_W+1)'(BND_BEATS) - {1'b0, off};
        c      = 9'(MAX_BURST_BEATS);
        if (64'(to_bnd) < 64'(c)) c = 9'(to_bnd);
        if (64'(beats) < 64'(c))  c = 9'(beats);
        return c;
    endfunction

    always_comb begin
        aligned    = i_req_addr & ~LOW_MASK;
        req_chunk  = chunk_of(aligned[BND_LOG2-1:BEAT_LOG2], i_req_beats);
        next_addr  = addr + (AW'(chunk) << BEAT_LOG2);
        next_rem   = rem - LEN_WIDTH'(chunk);
        next_chunk = chunk_of(next_addr[BND_LOG2-1:BEAT_LOG2], next_rem);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            rem         <= '0;
            chunk       <= '0;
            o_req_ready <= 1'b0;
            o_ar_valid  <= 1'b0;
            o_ar_addr   <= '0;
            o_ar_len    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    if (i_req_valid && o_req_ready) begin
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        addr        <= aligned;
                        rem         <= i_req_beats;
                        if (i_req_beats != '0) begin
                            chunk      <= req_chunk;
                            o_ar_valid <= 1'b1;
                            o_ar_addr  <= aligned;
                            o_ar_len   <= 8'(req_chunk - 9'd1);
                            state      <= ISSUE;
                        end else begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    // Next burst is loaded on the handshake edge so AR stays back-to-back
                    if (i_ar_ready) begin
                        addr <= next_addr;
                        rem  <= next_rem;
                        if (next_rem != '0) begin
                            chunk     <= next_chunk;
                            o_ar_addr <= next_addr;
                            o_ar_len  <= 8'(next_chunk - 9'd1);
                        end else begin
                            o_ar_valid <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    o_busy      <= 1'b0;
                    o_req_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmem_burst_splitter.sv
// Directed bench for gmem_burst_splitter (512-bit data, 64-beat max, 4 KiB lines).
module tb_gmem_burst_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [31:0] req_beats = '0;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gmem_burst_splitter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_beats (req_beats),
        .o_ar_valid  (ar_valid),
        .i_ar_ready  (ar_ready),
        .o_ar_addr   (ar_addr),
        .o_ar_len    (ar_len),
        .o_busy      (busy),
        .o_done      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [63:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_beats = b;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Expects a burst presented now; holds ar_ready low for 'stall' cycles then accepts it
    task automatic expect_ar(input logic [63:0] a, input logic [7:0] len, input int stall);
        chk("ar_valid", {63'd0, ar_valid}, 64'd1);
        chk("ar_addr", ar_addr, a);
        chk("ar_len", {56'd0, ar_len}, {56'd0, len});
        chk("no_early_done", {63'd0, done}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, ar_valid}, 64'd1);
            chk("stall_addr", ar_addr, a);
            chk("stall_len", {56'd0, ar_len}, {56'd0, len});
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
    endtask

    task automatic expect_done();
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("done_cleared", {63'd0, done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_ready", {63'd0, req_ready}, 64'd1);
        chk("idle_ar_valid", {63'd0, ar_valid}, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("rst_ar_addr", ar_addr, 64'd0);
        chk("rst_ar_len", {56'd0, ar_len}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

        // Line-crossing request, first burst stalled 5 cycles
        send(64'h0F80, 32'd8);
        expect_ar(64'h0F80, 8'd1, 5);
        expect_ar(64'h1000, 8'd5, 0);
        expect_done();

        // Max-burst splitting, back-to-back bursts
        send(64'h0, 32'd200);
        expect_ar(64'h0000, 8'd63, 0);
        expect_ar(64'h1000, 8'd63, 0);
        expect_ar(64'h2000, 8'd63, 0);
        expect_ar(64'h3000, 8'd7, 0);
        expect_done();

        // Zero-beat request
        send(64'h40, 32'd0);
        chk("zero_no_ar", {63'd0, ar_valid}, 64'd0);
        expect_done();

        // Misaligned start address
        send(64'h1234, 32'd1);
        expect_ar(64'h1200, 8'd0, 0);
        expect_done();

        // Address wrap at the top of the address space
        send(64'hFFFF_FFFF_FFFF_FFC0, 32'd2);
        expect_ar(64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 0);
        expect_ar(64'h0, 8'd0, 0);
        expect_done();

        // Reset during the second of four bursts
        send(64'h0, 32'd200);
        expect_ar(64'h0000, 8'd63, 0);
        chk("mid_ar_addr", ar_addr, 64'h1000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("mid_rst_ar_addr", ar_addr, 64'd0);
        chk("mid_rst_ar_len", {56'd0, ar_len}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", {63'd0, done}, 64'd0);
            chk("post_rst_no_ar", {63'd0, ar_valid}, 64'd0);
        end
        send(64'h1234, 32'd1);
        expect_ar(64'h1200, 8'd0, 0);
        expect_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
